// File: rtl/fifo_rd_skid.sv
// Read-side output stage of the async FIFO: pops words into a 2-entry skid buffer
// and presents them on a registered valid/ready stream.
module fifo_rd_skid #(
    parameter int DataWidth = 8
) (
    input  logic                 clk_rd,
    input  logic                 rst_rd_n,
    input  logic                 i_empty,
    input  logic [DataWidth-1:0] i_rd_data,
    output logic                 o_rd_en,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DataWidth-1:0] o_data,
    output logic [1:0]           o_level
);

    // Handshake: a word transfers on a rising edge where o_valid=1 and i_ready=1;
    // o_valid and o_data hold while o_valid=1 and i_ready=0, and i_ready is
    // ignored while o_valid=0.

    logic [1:0]           level_q, level_d;
    logic [DataWidth-1:0] head_q, head_d;
    logic [DataWidth-1:0] tail_q, tail_d;
    logic                 pop;
    logic                 deq;

    // The pop request depends only on the registered level and the flag, so
    // downstream backpressure never reaches the read controller in one cycle.
    always_comb begin
        pop = ~i_empty & (level_q != 2'd2);
        deq = (level_q != 2'd0) & i_ready;
    end

    always_comb begin
        level_d = level_q + {1'b0, pop} - {1'b0, deq};
        head_d  = head_q;
        tail_d  = tail_q;
        case ({deq, pop})
            2'b01: begin
                if (level_q == 2'd0) begin
                    head_d = i_rd_data;
                end else begin
                    tail_d = i_rd_data;
                end
            end
            2'b10: begin
                head_d = tail_q;
            end
            2'b11: begin
                // Only reachable at level 1: the head leaves and the new word replaces it.
                head_d = i_rd_data;
            end
            default: begin
                head_d = head_q;
            end
        endcase
    end

    always_ff @(posedge clk_rd or negedge rst_rd_n) begin
        if (!rst_rd_n) begin
            level_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            level_q <= level_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign o_rd_en = pop;
    assign o_valid = (level_q != 2'd0);
    assign o_data  = head_q;
    assign o_level = level_q;

endmodule

// File: tb/tb_fifo_rd_skid.sv
// Self-checking bench for fifo_rd_skid: directed cases plus a randomized stream
// compared against a queue-based model of the buffer.
module tb_fifo_rd_skid;

    localparam int W = 8;

    logic         clk_rd;
    logic         rst_rd_n;
    logic         i_empty;
    logic [W-1:0] i_rd_data;
    logic         o_rd_en;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_data;
    logic [1:0]   o_level;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] src_q[$];   // words the FIFO still holds
    logic [W-1:0] exp_q[$];   // words the buffer should hold, head first
    int           pushed_cnt;
    int           out_cnt;
    int           valid_seen;

    fifo_rd_skid #(.DataWidth(W)) dut (
        .clk_rd   (clk_rd),
        .rst_rd_n (rst_rd_n),
        .i_empty  (i_empty),
        .i_rd_data(i_rd_data),
        .o_rd_en  (o_rd_en),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_level  (o_level)
    );

    initial begin
        clk_rd = 1'b0;
        forever #5 clk_rd = ~clk_rd;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One read-clock cycle: drive inputs, check against the model, toggle i_ready
    // to confirm o_rd_en ignores it, then advance the model across the edge.
    task automatic run_cycle(input bit gap, input bit rdy);
        bit           exp_rd_en;
        bit           exp_deq;
        logic [W-1:0] w;
        i_empty   = gap || (src_q.size() == 0);
        i_rd_data = (src_q.size() != 0) ? src_q[0] : W'($urandom);
        i_ready   = rdy;
        #2;
        exp_rd_en = !i_empty && (exp_q.size() < 2);
        exp_deq   = (exp_q.size() != 0) && rdy;
        check_eq("level", 32'(o_level), 32'(exp_q.size()));
        check_eq("valid", 32'(o_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check_eq("data", 32'(o_data), 32'(exp_q[0]));
        check_eq("rd_en", 32'(o_rd_en), 32'(exp_rd_en));
        i_ready = ~rdy;
        #1;
        check_eq("rd_en_iso", 32'(o_rd_en), 32'(exp_rd_en));
        i_ready = rdy;
        @(posedge clk_rd);
        if (exp_deq) begin
            void'(exp_q.pop_front());
            out_cnt++;
        end
        if (exp_rd_en) begin
            w = src_q.pop_front();
            exp_q.push_back(w);
        end
        #1;
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            src_q.push_back(W'(first + i));
            pushed_cnt++;
        end
    endtask

    initial begin
        pushed_cnt = 0;
        out_cnt    = 0;
        rst_rd_n   = 1'b0;
        i_empty    = 1'b1;
        i_rd_data  = '0;
        i_ready    = 1'b0;
        #3;
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_level", 32'(o_level), 32'd0);
        check_eq("rst_data", 32'(o_data), 32'd0);
        check_eq("rst_rd_en", 32'(o_rd_en), 32'd0);
        @(posedge clk_rd);
        #1;
        rst_rd_n = 1'b1;

        // Single word after five idle cycles.
        for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b1);
        src_q.push_back(8'hA5);
        pushed_cnt++;
        run_cycle(1'b0, 1'b1);
        #2;
        check_eq("single_valid", 32'(o_valid), 32'd1);
        check_eq("single_data", 32'(o_data), 32'hA5);
        run_cycle(1'b1, 1'b1);
        #2;
        check_eq("single_drained", 32'(o_level), 32'd0);
        run_cycle(1'b1, 1'b1);

        // Streaming at one word per cycle.
        push_words(8'h00, 16);
        valid_seen = 0;
        run_cycle(1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            #2;
            if (o_valid) valid_seen++;
            if (i < 16) check_eq("stream_level", 32'(o_level), 32'd1);
            run_cycle(1'b0, 1'b1);
        end
        check_eq("stream_valid_cycles", 32'(valid_seen), 32'd16);

        // Backpressure with three words waiting, then resume without a gap.
        push_words(8'h10, 3);
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b0);
        #2;
        check_eq("bp_level", 32'(o_level), 32'd2);
        check_eq("bp_rd_en", 32'(o_rd_en), 32'd0);
        check_eq("bp_head", 32'(o_data), 32'h10);
        run_cycle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #2;
            check_eq("resume_valid", 32'(o_valid), 32'd1);
            check_eq("resume_data", 32'(o_data), 32'(8'h10 + i));
            run_cycle(1'b0, 1'b1);
        end
        run_cycle(1'b1, 1'b1);

        // Asynchronous reset with a full buffer.
        push_words(8'h20, 3);
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b0);
        #2;
        rst_rd_n = 1'b0;
        i_empty  = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(o_valid), 32'd0);
        check_eq("mid_rst_level", 32'(o_level), 32'd0);
        check_eq("mid_rst_data", 32'(o_data), 32'd0);
        check_eq("mid_rst_rd_en", 32'(o_rd_en), 32'd0);
        exp_q.delete();
        src_q.delete();
        @(posedge clk_rd);
        #1;
        rst_rd_n = 1'b1;
        run_cycle(1'b1, 1'b1);
        run_cycle(1'b1, 1'b0);

        // Randomized stream of 1000 words with gaps and backpressure.
        out_cnt    = 0;
        pushed_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            src_q.push_back(W'($urandom));
            pushed_cnt++;
        end
        for (int cyc = 0; cyc < 20000 && out_cnt < pushed_cnt; cyc++) begin
            run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end
        check_eq("random_words_out", 32'(out_cnt), 32'(pushed_cnt));
        check_eq("random_src_empty", 32'(src_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_skid.md
# fifo_rd_skid

Read-side output stage of the async FIFO, placed directly downstream of the read pointer controller and the memory read port, in the read clock domain. It pops words whenever the FIFO reports non-empty and its own buffer has room, and presents them on a registered valid/ready stream. The 2-entry skid buffer sustains one word per cycle. No combinational path exists from `i_ready` to `o_rd_en`, so downstream backpressure never reaches the pointer logic in the same cycle.

## Interface
- `DataWidth`, default 8, width of one FIFO word
- `clk_rd`  in  1  read-domain clock, all state on rising edge
- `rst_rd_n`  in  1  asynchronous active-low reset
- `i_empty`  in  1  FIFO empty flag from the read controller (registered there)
- `i_rd_data`  in  DataWidth  memory word at the current read pointer; valid whenever `i_empty`=0
- `o_rd_en`  out  1  pop request to the read controller
- `o_valid`  out  1  output word valid
- `i_ready`  in  1  downstream accepts the word
- `o_data`  out  DataWidth  output word (head of the skid buffer)
- `o_level`  out  2  buffer occupancy, 0..2

## Operation
- Storage: two registered slots, `head` and `tail`. `o_data` is `head`. `o_level` is the registered count.
- `o_rd_en = ~i_empty & (o_level != 2)`. This is combinational from registered/flag inputs only; `i_ready` never enters it.
- `pop = o_rd_en`. On the clock edge where `pop`=1, `i_rd_data` is captured into the buffer.
- `deq = o_valid & i_ready`. `i_ready` is ignored while `o_valid`=0.
- `o_valid = (o_level != 0)`, driven from the registered level.
- Next level is `o_level + pop - deq`. It never exceeds 2 and never drops below 0.
- Slot update per edge:
  - deq=0, pop=1: write to `head` if level 0, else to `tail`.
  - deq=1, pop=0: `head <= tail` (when level 2); `tail` becomes don't-care.
  - deq=1, pop=1, level 1: `head <= i_rd_data`.
  - deq=1, pop=1, level 2: cannot occur, because pop is blocked at level 2.
  - deq=0, pop=0: hold.
- Ordering is strict FIFO. No word is dropped or duplicated.
- Stability: while `o_valid`=1 and `i_ready`=0, `o_data` and `o_valid` hold unchanged.
- Reset, asynchronous, any time including mid-stream:
  - `o_level`=0, `o_valid`=0, `o_data`=0, `tail`=0.
  - `o_rd_en`=0, since the read controller also resets `i_empty`=1.
  - Buffered words are discarded.
  - Reset release needs no extra handshake; popping resumes on the first cycle `i_empty`=0.

## Timing
- Latency from `i_empty` falling (cycle t, `o_rd_en`=1 in t) to `o_valid`=1 is 1 cycle (t+1). The word captured at edge t+1 equals `i_rd_data` during t.
- Throughput: with `i_ready` held 1, level stays at 1. Pop and deq occur every cycle, giving 1 word/cycle.
- Backpressure: with `i_ready`=0, level reaches 2 after two pops, and `o_rd_en` drops in the cycle level reads 2.
- Resume: the first `i_ready`=1 cycle at level 2 dequeues without a pop. Popping restarts the next cycle (level 1), so there is no bubble on the output.
- Empty boundary: `i_empty`=1 gives `o_rd_en`=0 regardless of level. The buffer keeps draining normally.
- The block relies on the read controller's `i_empty` being updated at the same edge as its pointer increment. A pop at edge e therefore never reads stale data at e+1.

## Test plan
- Reset: assert `rst_rd_n`=0 mid-stream with level 2 -> immediately `o_valid`=0, `o_level`=0, `o_data`=0; after release with `i_empty`=1, `o_rd_en`=0.
- Single word: `i_empty` falls at cycle 5 with `i_rd_data`=0xA5, `i_ready`=1 -> `o_rd_en`=1 at cycle 5 only (then `i_empty`=1), `o_valid`=1 with `o_data`=0xA5 at cycle 6, `o_level` back to 0 at cycle 7.
- Streaming: 16 words 0x00..0x0F, `i_ready`=1 constant -> `o_valid` high for 16 consecutive cycles, data in order, `o_level`=1 throughout.
- Backpressure: `i_ready`=0, FIFO holds 0x10,0x11,0x12 -> two pops, `o_level`=2, `o_rd_en`=0 with `i_empty`=0, `o_data`=0x10 held. Then `i_ready`=1 -> outputs 0x10,0x11,0x12 on consecutive cycles with no gap.
- Random: random `i_ready` (50%) and random `i_empty` gaps, 1000 words -> output sequence equals input sequence, `o_level`≤2 always, and `o_data` is stable while `o_valid & ~i_ready`.
- Combinational isolation: toggle `i_ready` in a cycle with `o_level` and `i_empty` fixed -> `o_rd_en` unchanged within that cycle.
